ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xF4 Enable Data Reporting, 0xFF Reset) from the FPGA to the PS/2 mouse using the standard request-to-send sequence. It sits beside the PS/2 receive path inside the mouse interface. The top level converts its open-drain enables into the `PS2_CLK` / `PS2_DATA` inouts. It shares those lines with the receiver, which is held off while `busy` is high.

## Interface
- `INHIBIT_CYCLES`, default 12000: number of cycles `ps2_clk_oe` holds the clock low before RTS (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 200000: maximum number of cycles from clock release to ACK completion (2 ms at 100 MHz).
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-low reset.
- `tx_data`  in  8  command byte; sampled on the cycle `tx_start` is accepted.
- `tx_start`  in  1  one-cycle request; ignored while `busy`=1.
- `ps2_clk_in`  in  1  raw pin value of `PS2_CLK` (asynchronous).
- `ps2_data_in`  in  1  raw pin value of `PS2_DATA` (asynchronous).
- `ps2_clk_oe`  out  1  1 = drive `PS2_CLK` low; 0 = release.
- `ps2_data_oe`  out  1  1 = drive `PS2_DATA` low; 0 = release.
- `busy`  out  1  transfer in progress.
- `tx_done`  out  1  one-cycle pulse at the end of every transfer, successful or not.
- `tx_err`  out  1  one-cycle pulse, coincident with `tx_done`, when the transfer failed (missing ACK or timeout).

## Operation
- Both pin inputs pass through a 2-FF synchronizer, followed by one more register for edge detection. `fall` = previous 1 and current 0 on the synchronized clock.
- The byte is shifted into `shreg[9:0]` as {stop=1, parity=~^tx_data, tx_data}; the LSB goes out first. Parity is odd.
- States:
  - IDLE: both `oe` = 0. On `tx_start`: load `shreg`, clear counters, go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1, `ps2_data_oe`=0 for `INHIBIT_CYCLES` cycles, then RTS.
  - RTS: one cycle with `ps2_clk_oe`=1 and `ps2_data_oe`=1 (this is the start bit), then SEND. The timeout counter is cleared.
  - SEND: `ps2_clk_oe`=0. The start bit stays driven (`ps2_data_oe`=1) until the first `fall`.
    - On each `fall`, `bitcnt` increments. For `bitcnt` 1..10 after the increment, `ps2_data_oe` = ~`shreg[bitcnt-1]`.
    - Edges 1–8 present data bits d0..d7, edge 9 the parity bit, edge 10 the stop bit (released).
    - On the 11th `fall`, sample synchronized data: 0 = ACK seen, 1 = no ACK. Go to WAIT_IDLE.
  - WAIT_IDLE: both `oe` = 0. Wait until the synchronized clock and data are both 1, then pulse `tx_done`. If no ACK was seen, `tx_err`=1 in the same cycle. Go to IDLE.
- Timeout: a counter runs in SEND and WAIT_IDLE. When it reaches `TIMEOUT_CYCLES`:
  - next cycle both `oe` = 0;
  - `tx_done` and `tx_err` pulse;
  - state returns to IDLE.
- `busy` = 1 in every state except IDLE.
- The block never drives a line high; a released line reads 1 only through the external pull-up.

## Timing
- Reset values: state IDLE; `ps2_clk_oe`, `ps2_data_oe`, `busy`, `tx_done`, `tx_err` all 0; `bitcnt`=0; all counters 0.
- Reset mid-transfer (`rst`=0 at any state): both `oe` = 0 at the next clock edge. No `tx_done` pulse is generated.
- `tx_start` accepted at edge T: `busy`=1 and `ps2_clk_oe`=1 from T+1.
  - `ps2_clk_oe` stays high for `INHIBIT_CYCLES`+1 cycles, the last one being RTS.
  - `ps2_data_oe`=1 from T+1+`INHIBIT_CYCLES`.
- A pin falling edge updates `ps2_data_oe` 3 cycles later (2-cycle sync plus 1-cycle edge register). This is well inside the device's ≥5 µs clock-low half period.
- `tx_start` while `busy` is dropped. `tx_data` is not re-sampled.
- `tx_start` in the same cycle as the `tx_done` pulse is ignored; it is accepted from the following cycle onward.
- `tx_done` lasts exactly one cycle. `busy` falls in the cycle after `tx_done`.
- Bench overrides for simulation: `INHIBIT_CYCLES`=20, `TIMEOUT_CYCLES`=2000.

## Test plan
- **Send 0xF4, device model ACKs.** Pin data read at device clock rises must be 0 (start), 0,0,1,0,1,1,1,1, 0 (parity), 1 (stop). ACK low on the 11th edge. Expect `tx_done`=1, `tx_err`=0, `busy` back to 0.
- **Send 0x00.** Parity bit must be 1. Expect `ps2_clk_oe` held exactly 20 cycles, then one RTS cycle.
- **Device clocks all 11 edges but leaves data high on edge 11.** Expect `tx_done`=1 and `tx_err`=1 together, then IDLE.
- **Device never clocks after release.** Expect `tx_done` and `tx_err` exactly 2000 cycles after the RTS cycle, with both `oe` = 0 after that.
- **Second `tx_start` (0xFF) during SEND of 0xF4.** The transmitted byte must remain 0xF4. No second transfer starts.
- **`rst`=0 asserted after the 5th falling edge.** Next cycle: `ps2_clk_oe`=0, `ps2_data_oe`=0, `busy`=0, no `tx_done`. After reset is released, a fresh 0xF4 transfer completes correctly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ACK check)
// Ports:
//   clk, rst          system clock; synchronous active-low reset
//   tx_data, tx_start command byte and one-cycle request (dropped while busy)
//   ps2_clk_in/_data_in  raw pin values (asynchronous)
//   ps2_clk_oe/_data_oe  1 = pull the line low, 0 = release
//   busy, tx_done, tx_err  status; done/err pulse for one cycle at the end of a transfer
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, WAIT_IDLE} state_t;
  state_t state_q, state_d;
  logic [9:0] shreg_q, shreg_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ack_q, ack_d;
  logic clk_oe_q, clk_oe_d;
  logic data_oe_q, data_oe_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic [2:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic fall, start_ok, lines_idle;
  // [1] is the synchronized value, [2] the extra edge-detect stage
  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign lines_idle = clk_sync_q[1] & data_sync_q[1];
  // busy_q is still high in the tx_done cycle, so a start there is dropped
  assign start_ok = tx_start & ~busy_q;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bitcnt_d = bitcnt_q;
    cnt_d = cnt_q;
    ack_d = ack_q;
    clk_oe_d = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: begin
        clk_oe_d = start_ok;
        data_oe_d = 1'b0;
        busy_d = start_ok;
        if (start_ok) begin
          state_d = INHIBIT;
          shreg_d = {1'b1, ~^tx_data, tx_data};
          bitcnt_d = '0;
          cnt_d = '0;
          ack_d = 1'b0;
        end
      end
      INHIBIT: begin
        cnt_d = cnt_q == INH_LAST ? '0 : cnt_q + CW'(1);
        if (cnt_q == INH_LAST) begin
          state_d = RTS;
          data_oe_d = 1'b1;
        end
      end
      RTS: begin
        state_d = SEND;
        clk_oe_d = 1'b0;
        // the timeout count includes the RTS cycle itself
        cnt_d = CW'(1);
      end
      SEND, WAIT_IDLE: begin
        if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          clk_oe_d = 1'b0;
          data_oe_d = 1'b0;
          done_d = 1'b1;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == SEND && fall) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd10) begin
              ack_d = ~data_sync_q[1];
              data_oe_d = 1'b0;
              state_d = WAIT_IDLE;
            end else begin
              data_oe_d = ~shreg_q[bitcnt_q];
            end
          end else if (state_q == WAIT_IDLE && lines_idle) begin
            state_d = IDLE;
            done_d = 1'b1;
            err_d = ~ack_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bitcnt_q <= '0;
      cnt_q <= '0;
      ack_q <= 1'b0;
      clk_oe_q <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      clk_sync_q <= '1;
      data_sync_q <= '1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bitcnt_q <= bitcnt_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      clk_oe_q <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
    end
  end
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy = busy_q;
  assign tx_done = done_q;
  assign tx_err = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a behavioural PS/2 device model
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TO = 2000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
  logic clk_pin, data_pin;
  assign clk_pin = dev_clk & ~ps2_clk_oe;
  assign data_pin = dev_data & ~ps2_data_oe;
  int checks = 0;
  int failures = 0;
  typedef struct {logic [10:0] frame; bit err; bit has_frame;} exp_t;
  exp_t exp_q[$];
  logic [10:0] got_q[$];
  exp_t e;
  bit prev_done = 0;
  always #5 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(clk_pin), .ps2_data_in(data_pin),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Wire-level frame as the device sees it: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2) == 0;
    return {1'b1, par, b, 1'b0};
  endfunction
  always @(negedge clk) begin
    if (prev_done) begin
      chk("done_one_cycle", tx_done, 0);
      chk("busy_after_done", busy, 0);
    end
    if (tx_err && !tx_done) begin
      checks++;
      failures++;
      $display("FAIL err_without_done: tx_err=1 tx_done=0");
    end
    if (tx_done) begin
      chk("busy_during_done", busy, 1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: tx_done=1 with no transfer pending");
      end else begin
        e = exp_q.pop_front();
        chk("tx_err", tx_err, e.err);
        if (e.has_frame) begin
          if (got_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_missing: no frame captured, expected %0h", e.frame);
          end else chk("frame", got_q.pop_front(), e.frame);
        end
      end
    end
    prev_done = tx_done;
  end
  // mode 0: ACK, 1: data left high on edge 11, 2: never clocks; stop_after>0 aborts after that fall
  task automatic dev_frame(input int mode, input int h, input int stop_after);
    logic [10:0] f;
    int n;
    n = 0;
    f = '0;
    while (!(clk_pin && !data_pin && busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL rts_wait: request-to-send not seen within 200 cycles");
      return;
    end
    if (mode == 2) return;
    repeat (h) @(negedge clk);
    f[0] = data_pin;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && mode == 0) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (h) @(negedge clk);
      if (k == stop_after) return;
      dev_clk = 1'b1;
      if (k <= 10) f[k] = data_pin;
      if (k == 10) got_q.push_back(f);
      repeat (h) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask
  task automatic start(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s: busy still 1 after 5000 cycles", name);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input int mode, input int h);
    exp_q.push_back('{frame_of(b), mode != 0, mode != 2});
    start(b);
    dev_frame(mode, h, 0);
    wait_idle("send_idle");
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bit any;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send(8'hF4, 0, 8);
    exp_q.push_back('{frame_of(8'h00), 1'b0, 1'b1});
    start(8'h00);
    chk("inhibit_busy", busy, 1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_len", n, INH);
    chk("rts_clk_oe", ps2_clk_oe, 1);
    chk("rts_data_oe", ps2_data_oe, 1);
    @(negedge clk);
    chk("send_clk_oe", ps2_clk_oe, 0);
    chk("send_start_bit", ps2_data_oe, 1);
    dev_frame(0, 7, 0);
    wait_idle("zero_idle");
    send(8'hA5, 1, 9);
    exp_q.push_back('{11'h0, 1'b1, 1'b0});
    start(8'h3C);
    n = 0;
    while (!(ps2_clk_oe && ps2_data_oe) && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!tx_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_len", n, TO);
    chk("timeout_clk_oe", ps2_clk_oe, 0);
    chk("timeout_data_oe", ps2_data_oe, 0);
    @(negedge clk);
    chk("timeout_after_clk_oe", ps2_clk_oe, 0);
    chk("timeout_after_data_oe", ps2_data_oe, 0);
    wait_idle("timeout_idle");
    exp_q.push_back('{frame_of(8'hF4), 1'b0, 1'b1});
    start(8'hF4);
    fork
      dev_frame(0, 10, 0);
      begin
        repeat (40) @(negedge clk);
        tx_data = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    wait_idle("busy_start_idle");
    any = 0;
    repeat (30) begin
      @(negedge clk);
      any |= busy;
    end
    chk("no_second_transfer", any, 0);
    start(8'hF4);
    dev_frame(0, 8, 5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_clk_oe", ps2_clk_oe, 0);
    chk("midrst_data_oe", ps2_data_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", tx_done, 0);
    rst = 1'b1;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (5) @(negedge clk);
    send(8'hF4, 0, 8);
    for (int i = 0; i < 8; i++) send(8'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(5, 12)));
    repeat (10) @(negedge clk);
    chk("pending_exp", exp_q.size(), 0);
    chk("pending_frames", got_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
